// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the data-memory port and the load/store lane formatter.
package dm_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic [2:0] {DM_LB, DM_LH, DM_LW, DM_LBU, DM_LHU, DM_SB, DM_SH, DM_SW} dm_type_e;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'b00);
  endfunction
endpackage

// File: rtl/dm_byte_ram.sv
// dm_byte_ram: DEPTH x 32 block RAM with per-byte write enables and a registered read port.
module dm_byte_ram #(
  parameter int DEPTH = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        wea,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && wea[i]) mem[waddr][8*i+:8] <= wdata[8*i+:8];
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/dm_mem_port.sv
// dm_mem_port: MEM-stage data-memory port with load latency FSM and pipeline stall.
// Define DM_MISALIGN_TRAP_EN to add req_size/misalign_err and drop misaligned accesses.
module dm_mem_port
  import dm_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int READ_LAT = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wea,
`ifdef DM_MISALIGN_TRAP_EN
  input  logic [1:0]  req_size,
  output logic        misalign_err,
`endif
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        stall
);
  state_e state_q, state_d;
  logic [1:0] lat_q, lat_d;
  logic [ADDR_W-1:0] idx_q, idx_d, idx, raddr;
  logic [31:0] rdata_q, rdata_d, ram_rdata;
  logic accept, mis, ram_we, ld_go, unused_ok;
  assign idx = req_addr[ADDR_W+1:2];
  assign unused_ok = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
  assign req_ready = (state_q == IDLE) & ~rst;
  assign accept = req_valid & req_ready;
`ifdef DM_MISALIGN_TRAP_EN
  logic mis_q;
  assign mis = misaligned(req_size, req_addr[1:0]);
  assign misalign_err = mis_q;
  always_ff @(posedge clk) mis_q <= ~rst & accept & mis;
`else
  assign mis = 1'b0;
`endif
  assign ram_we = accept & req_we & ~mis;
  assign ld_go = accept & ~req_we & ~mis;
  // Address the RAM straight from the request in IDLE so the read starts at the accept edge.
  assign raddr = (state_q == IDLE) ? idx : idx_q;
  assign stall = (req_valid & ~req_we & req_ready & ~mis) | (state_q == BUSY);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  always_comb begin
    state_d = (state_q == IDLE) ? (ld_go ? BUSY : IDLE) :
              (state_q == BUSY) ? ((lat_q == 2'd0) ? RESP : BUSY) : IDLE;
    lat_d = ld_go ? 2'(READ_LAT - 1) :
            (state_q == BUSY && lat_q != 2'd0) ? lat_q - 2'd1 : lat_q;
    idx_d = ld_go ? idx : idx_q;
    rdata_d = (state_q == BUSY && lat_q == 2'd0) ? ram_rdata : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q <= 2'd0;
      idx_q <= '0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      lat_q <= lat_d;
      idx_q <= idx_d;
      rdata_q <= rdata_d;
    end
  end
  dm_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(ram_we),
    .wea(req_wea),
    .waddr(idx),
    .wdata(req_wdata),
    .raddr(raddr),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_dm_mem_port.sv
// tb_dm_mem_port: scoreboard bench for dm_mem_port with READ_LAT=3.
module tb_dm_mem_port;
  import dm_pkg::*;
  localparam int READ_LAT = 3;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_we = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_wea = 0;
  logic req_ready, rsp_valid, stall;
  logic [31:0] rsp_rdata;
  logic [1:0] req_size = SZ_WORD;
`ifdef DM_MISALIGN_TRAP_EN
  logic misalign_err;
`endif
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [31:0] exp_q[$];
  int cyc_q[$];
  dm_mem_port #(.DEPTH(1024), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wea(req_wea),
`ifdef DM_MISALIGN_TRAP_EN
    .req_size(req_size), .misalign_err(misalign_err),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .stall(stall)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  logic [31:0] m_exp;
  int m_cyc;
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        m_exp = exp_q.pop_front();
        m_cyc = cyc_q.pop_front();
        chk("rsp_rdata", rsp_rdata, m_exp);
        chk("rsp_latency", 32'(cyc - m_cyc), 32'(READ_LAT + 1));
      end
    end
  end
  // Called just after a rising edge; returns after the accept edge with req_valid dropped.
  task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic [1:0] sz, input logic [31:0] exp,
                      input bit push, output int waits);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_wea = m; req_size = sz;
    #1;
    waits = 0;
    while (!req_ready && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    chk("accept_timeout", 32'(req_ready), 32'd1);
    chk("stall_at_accept", 32'(stall), 32'(!we));
    if (!we && push) begin
      exp_q.push_back(exp);
      cyc_q.push_back(cyc);
    end
    @(posedge clk); #1;
    req_valid = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  int w;
  initial begin
    @(posedge clk); #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 0;
    #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    idle(1);
    xfer(1, 32'h10, 32'hDEADBEEF, 4'b1111, SZ_WORD, 0, 0, w);
    xfer(0, 32'h10, 0, 4'b0000, SZ_WORD, 32'hDEADBEEF, 1, w);
    for (int i = 0; i < READ_LAT; i++) begin
      chk("stall_busy", 32'(stall), 32'd1);
      chk("ready_busy", 32'(req_ready), 32'd0);
      idle(1);
    end
    chk("stall_resp", 32'(stall), 32'd0);
    chk("ready_resp", 32'(req_ready), 32'd0);
    idle(1);
    chk("ready_after_resp", 32'(req_ready), 32'd1);
    xfer(1, 32'h20, 32'h11223344, 4'b1111, SZ_WORD, 0, 0, w);
    xfer(1, 32'h22, 32'hAAAAAAAA, 4'b0100, SZ_HALF, 0, 0, w);
    xfer(1, 32'h24, 32'h55667788, 4'b1111, SZ_WORD, 0, 0, w);
    xfer(0, 32'h20, 0, 4'b0000, SZ_WORD, 32'h11AA3344, 1, w);
    xfer(0, 32'h24, 0, 4'b0000, SZ_WORD, 32'h55667788, 1, w);
    chk("held_wait_cycles", 32'(w), 32'(READ_LAT + 1));
    idle(READ_LAT + 2);
    xfer(0, 32'h10, 0, 4'b0000, SZ_WORD, 0, 0, w);
    rst = 1;
    idle(1);
    rst = 0;
    #1;
    chk("midload_rst_stall", 32'(stall), 32'd0);
    chk("midload_rst_ready", 32'(req_ready), 32'd1);
    idle(READ_LAT + 3);
    xfer(1, 32'h00001000, 32'hCAFEF00D, 4'b1111, SZ_WORD, 0, 0, w);
    xfer(0, 32'h00000000, 0, 4'b0000, SZ_WORD, 32'hCAFEF00D, 1, w);
    idle(READ_LAT + 1);
    xfer(1, 32'h10, 32'h00000000, 4'b0000, SZ_WORD, 0, 0, w);
    xfer(0, 32'h10, 0, 4'b0000, SZ_WORD, 32'hDEADBEEF, 1, w);
    idle(READ_LAT + 1);
`ifdef DM_MISALIGN_TRAP_EN
    xfer(1, 32'h30, 32'h01020304, 4'b1111, SZ_WORD, 0, 0, w);
    chk("misalign_idle", 32'(misalign_err), 32'd0);
    xfer(1, 32'h32, 32'hFFFFFFFF, 4'b1111, SZ_WORD, 0, 0, w);
    chk("misalign_pulse", 32'(misalign_err), 32'd1);
    idle(1);
    chk("misalign_clear", 32'(misalign_err), 32'd0);
    xfer(0, 32'h30, 0, 4'b0000, SZ_WORD, 32'h01020304, 1, w);
    idle(READ_LAT + 1);
    xfer(0, 32'h32, 0, 4'b0000, SZ_HALF, 32'h01020304, 1, w);
    chk("half_no_err", 32'(misalign_err), 32'd0);
    idle(READ_LAT + 1);
`endif
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_mem_port.md
Name: dm_mem_port

Overview:
- Data-memory port that sits directly downstream of the load/store lane formatter in the MEM stage.
- Accepts one request per handshake: byte-lane-replicated store data plus a 4-bit byte write mask, or a word load.
- Owns the byte-lane data RAM, which has synchronous writes and a configurable read latency.
- Returns the raw 32-bit word for the formatter to extract and sign-extend, and raises a pipeline stall while a load is outstanding.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, at least 4.
- ADDR_W, $clog2(DEPTH), word-index width; derived, not overridden.
- READ_LAT, 1, load latency in cycles from accept to rsp_valid; legal values 1 to 3.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  port can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; word index = req_addr[ADDR_W+1:2].
- req_wdata  in  32  lane-replicated store data.
- req_wea  in  4  byte write enables; bit i writes req_wdata[8i+7:8i].
- rsp_valid  out  1  one-cycle pulse; rsp_rdata is valid.
- rsp_rdata  out  32  full word read.
- stall  out  1  freeze upstream pipeline.

Behaviour:
- Reset values: req_ready=0 during the reset cycle, then 1. rsp_valid=0, rsp_rdata=0, stall=0, state=IDLE, lat_cnt=0. RAM contents are not cleared.
- Handshake: a request is accepted when req_valid & req_ready. req_ready = (state==IDLE) & ~rst.
- Accepted store:
  - RAM word written at that edge, byte lanes per req_wea; state stays IDLE; no response and no stall.
  - req_wea==0 is a legal no-op that still completes.
- Accepted load:
  - Word index latched; state -> BUSY with lat_cnt = READ_LAT-1.
- FSM IDLE -> BUSY -> RESP -> IDLE:
  - BUSY: lat_cnt decrements each cycle; at 0 the RAM output is registered into rsp_rdata and state -> RESP. For READ_LAT=1, BUSY lasts exactly one cycle.
  - RESP: rsp_valid=1 for exactly one cycle; rsp_rdata holds until the next load response. Next state IDLE.
- stall = req_valid & ~req_we in IDLE (combinational, same cycle as accept), OR state==BUSY. It is 0 in RESP, so the pipeline advances with the data.
- Latency: a load accepted at edge N gives rsp_valid high in the cycle after edge N+READ_LAT.
- Request while BUSY/RESP: req_ready=0; the request is not accepted and must be held by upstream, which is guaranteed because stall is high.
- Store-then-load to the same word on consecutive accepts: the load returns the post-store merged word; no hazard.
- Address aliasing: bits above ADDR_W+1 are ignored and wrap modulo DEPTH words; bits [1:0] are ignored by the RAM.
- Reset mid-load: the FSM returns to IDLE, the response is dropped, rsp_valid never pulses, and stall drops the next cycle.

Optional Feature:
- Macro: DM_MISALIGN_TRAP_EN.
- Enabled:
  - Extra ports: req_size in 2 (0 byte, 1 half, 2 word) and misalign_err out 1.
  - A request with a half address where addr[0]=1, or a word address where addr[1:0]!=0, is accepted but not performed: no write and no BUSY.
  - misalign_err pulses for one cycle on the edge after acceptance, and stall stays 0.
  - misalign_err resets to 0.
- Disabled: those ports are absent and low address bits are ignored as above.

Decomposition:
- Package dm_pkg holds:
  - the size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2);
  - the FSM state encoding (IDLE, BUSY, RESP);
  - the DMType constants shared with the lane formatter.
- One sub-module: dm_byte_ram (DEPTH x 32, four byte-lane write enables, registered read), inferred as block RAM. The FSM and latency counter stay in dm_mem_port.

Test Plan:
- Reset, then store addr=0x10, wdata=0xDEADBEEF, wea=1111; load addr=0x10 -> rsp_valid exactly READ_LAT+1 cycles after accept, rsp_rdata=0xDEADBEEF, stall high on the accept cycle and in BUSY only.
- Store 0x11223344 to 0x20; store wdata=0xAAAAAAAA wea=0100 to 0x22; load 0x20 -> 0x11AA3344.
- Load accepted while req_valid is held with a second load to 0x24 -> req_ready=0 through BUSY/RESP; second load accepted only after RESP; exactly two rsp_valid pulses.
- Assert rst in the BUSY cycle of a load with READ_LAT=3 -> no rsp_valid, stall=0 and req_ready=1 on the cycle after reset deasserts.
- DEPTH=1024: store to 0x00001000, load from 0x00000000 -> same data (alias); store with wea=0000 leaves the word unchanged.
- With DM_MISALIGN_TRAP_EN: word store to 0x32 -> misalign_err pulses for 1 cycle and the word at 0x30 is unchanged; half load at 0x32 -> normal response.
